banked_memory: RTL
==================

# banked_memory

Two-port, bank-interleaved synchronous memory that generalises the team's single-port `memory` (14-bit address, 10-bit data). Data width, address width and bank count are parameters. Two independent request ports can each complete one access per cycle when they target different banks. A per-bank round-robin arbiter resolves same-bank conflicts. Reads return through a registered `rvalid`/`rdata` path, so the block can sit behind the CPU core and a DMA/IO master at the same time.

## Interface
- `DATA_W`, default 10: word width.
- `ADDR_W`, default 14: word address width.
- `BANK_BITS`, default 1: number of bank-select bits; `NUM_BANKS = 2**BANK_BITS`.
  - Bank = `addr[ADDR_W-1 -: BANK_BITS]` (top bits).
  - Row = `addr[ADDR_W-BANK_BITS-1:0]`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: access request, port 0 / port 1.
- `we0`, `we1` in 1: 1 = write, 0 = read; qualified by `req`.
- `addr0`, `addr1` in `ADDR_W`: word address.
- `wdata0`, `wdata1` in `DATA_W`: write data.
- `gnt0`, `gnt1` out 1: combinational grant; the access is accepted at the rising edge where `req && gnt`.
- `rvalid0`, `rvalid1` out 1: read data valid, registered.
- `rdata0`, `rdata1` out `DATA_W`: read data, registered.

## Operation
- Port `p` is granted when `req_p` is high and either:
  - the other port is idle or targets a different bank, or
  - the ports conflict and `prio[bank] == p`.
- Grants are combinational from `req`, `addr` and `prio`. `we` and data do not affect arbitration.
- A losing port sees `gnt = 0`. It must hold `req`, `we`, `addr` and `wdata` stable until granted. The block does not queue requests.
- `prio[b]` is one bit per bank and resets to port 0.
  - It toggles to the losing port only in a cycle with a conflict in bank `b`.
  - It is unchanged otherwise.
  - Under sustained conflict the ports therefore alternate.
- Accepted write: `mem[bank][row] <= wdata` at that edge.
- Accepted read: at the same edge, `rdata_p <= mem[bank][row]` and `rvalid_p <= 1`.
- `rvalid_p` is a 1-cycle pulse per accepted read. `rdata_p` holds its last value while `rvalid_p = 0`.
- Read of an address written at an earlier edge returns the new data.
- Same-cycle read and write to one address cannot occur, because there is one access per bank per cycle.
- Reset behaviour:
  - Reset values: `rvalid0 = rvalid1 = 0`, `rdata0 = rdata1 = 0`, all `prio` bits = 0.
  - `gnt` is forced to 0 while `rst` is high, so no access is accepted.
  - Array contents are not reset and are retained across `rst`.
- Reset mid-operation: asserting `rst` clears an in-flight `rvalid` immediately (asynchronous). A request held through reset is re-arbitrated from `prio = 0` after release.

## Timing
- Read latency is 1 cycle: request accepted at edge N, `rvalid`/`rdata` valid from N until N+1.
- Write completes at the accepting edge.
- Maximum throughput is 2 accesses per cycle (different banks), or 1 per cycle per bank.
- Worst-case wait for a conflicting port is 1 cycle.
- The `gnt` path is combinational and `req`→`gnt` has no registered stage. Masters must not make `req` depend on `gnt` in the same cycle.

## Structure
- Package `memory_pkg`:
  - defaults for `DATA_W`, `ADDR_W` and `BANK_BITS`;
  - `localparam NUM_PORTS = 2`;
  - typedef `port_id_t` (1 bit);
  - function `bank_of(addr)`.
- Sub-module `mem_bank`: single-port synchronous RAM with depth `2**(ADDR_W-BANK_BITS)`, `we`, `en`, `addr`, `wdata`, registered `rdata`, no reset on the array. Instantiate `NUM_BANKS` times with a generate loop.
- Top level holds:
  - the bank-select decode;
  - the conflict/priority logic;
  - the per-bank port mux, where the granted port drives the bank;
  - the return-path routing, which is a registered bank-to-port select plus the `rvalid` flops.

## Test plan
- Write then read: port 0 writes 5 to addr 1, then reads addr 1 on the next cycle.
  - Required: `gnt0 = 1` in both cycles.
  - Required: `rvalid0` pulses one cycle after the read with `rdata0 = 5`.
- Parallel banks: with 7 preloaded at addr 1 and 9 at addr 8195, port 0 reads addr 1 while port 1 reads addr 8195 in the same cycle.
  - Required: both `gnt`s = 1.
  - Required: next cycle `rvalid0 = rvalid1 = 1`, `rdata0 = 7`, `rdata1 = 9`.
- Conflict round-robin: both ports read bank 0 (addr 1 and addr 2) and hold for 4 cycles.
  - Required grant order: port 0, port 1, port 0, port 1.
  - Required: `rvalid` pulses follow one cycle behind each grant.
- Mixed conflict: port 0 writes 3 to addr 4 while port 1 reads addr 4, same cycle, `prio[0] = 1`.
  - Required: port 1 is granted first and returns the old value.
  - Required: port 0 writes next cycle.
  - Required: a following read of addr 4 returns 3.
- Reset mid-operation: assert `rst` in the cycle `rvalid1 = 1`.
  - Required: `rvalid1` drops immediately and `gnt0 = gnt1 = 0` during reset.
  - Required: after release, `prio` is 0 and a read of previously written addr 1 still returns 5.
- Idle and hold: with `req0 = req1 = 0` for 3 cycles, `rvalid` stays at 0 and `rdata` holds its last value.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared defaults, port identifiers and address-decode helper for the banked memory.
package memory_pkg;
    localparam int DEFAULT_DATA_W    = 10;
    localparam int DEFAULT_ADDR_W    = 14;
    localparam int DEFAULT_BANK_BITS = 1;
    localparam int NUM_PORTS         = 2;

    typedef logic port_id_t;
    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    // Bank index is taken from the top bank_bits bits of the word address.
    function automatic int unsigned bank_of(input logic [31:0] addr,
                                            input int unsigned addr_w,
                                            input int unsigned bank_bits);
        return (addr >> (addr_w - bank_bits)) & ((32'd1 << bank_bits) - 32'd1);
    endfunction
endpackage

// File: rtl/mem_bank.sv
// Single-port synchronous RAM bank with registered read data and no array reset.
module mem_bank
    import memory_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ROW_W  = DEFAULT_ADDR_W - DEFAULT_BANK_BITS
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ROW_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ROW_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/banked_memory.sv
// Two-port bank-interleaved memory: per-bank round-robin arbitration, granted port
// drives the bank, read data returns one cycle later through a registered bank select.
module banked_memory
    import memory_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int BANK_BITS = DEFAULT_BANK_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);
    localparam int NUM_BANKS = 2**BANK_BITS;
    localparam int ROW_W     = ADDR_W - BANK_BITS;

    logic [BANK_BITS-1:0] bank0, bank1;
    logic [ROW_W-1:0]     row0, row1;
    logic                 conflict;
    logic [NUM_BANKS-1:0] prio_q, prio_d;

    assign bank0 = BANK_BITS'(bank_of(32'(addr0), ADDR_W, BANK_BITS));
    assign bank1 = BANK_BITS'(bank_of(32'(addr1), ADDR_W, BANK_BITS));
    assign row0  = addr0[ROW_W-1:0];
    assign row1  = addr1[ROW_W-1:0];

    assign conflict = req0 && req1 && (bank0 == bank1);
    assign gnt0 = !rst && req0 && (!conflict || prio_q[bank0] == PORT0);
    assign gnt1 = !rst && req1 && (!conflict || prio_q[bank1] == PORT1);

    // The winner of a conflict hands priority to the loser, so the ports alternate.
    always_comb begin
        prio_d = prio_q;
        if (conflict && !rst) begin
            prio_d[bank0] = ~prio_q[bank0];
        end
    end

    logic [NUM_BANKS-1:0] bank_en, bank_we;
    logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
    logic [DATA_W-1:0]    bank_wdata [NUM_BANKS];
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic hit0, hit1;
        assign hit0 = gnt0 && (bank0 == BANK_BITS'(gi));
        assign hit1 = gnt1 && (bank1 == BANK_BITS'(gi));

        assign bank_en[gi]    = hit0 || hit1;
        assign bank_we[gi]    = hit1 ? we1    : we0;
        assign bank_row[gi]   = hit1 ? row1   : row0;
        assign bank_wdata[gi] = hit1 ? wdata1 : wdata0;

        mem_bank #(
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[gi]),
            .we    (bank_we[gi]),
            .addr  (bank_row[gi]),
            .wdata (bank_wdata[gi]),
            .rdata (bank_rdata[gi])
        );
    end

    logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
    logic [BANK_BITS-1:0] sel_q  [NUM_PORTS];
    logic [BANK_BITS-1:0] sel_d  [NUM_PORTS];
    logic [DATA_W-1:0]    hold_q [NUM_PORTS];
    logic [DATA_W-1:0]    hold_d [NUM_PORTS];
    logic [DATA_W-1:0]    rdata_mux [NUM_PORTS];

    // Bank rdata is only trusted in the rvalid cycle; afterwards the port shows its own copy,
    // because another port may read the same bank later.
    always_comb begin
        rvalid_d[0] = gnt0 && !we0;
        rvalid_d[1] = gnt1 && !we1;
        sel_d[0]    = bank0;
        sel_d[1]    = bank1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdata_mux[p] = rvalid_q[p] ? bank_rdata[sel_q[p]] : hold_q[p];
            hold_d[p]    = rdata_mux[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            prio_q   <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                sel_q[p]  <= '0;
                hold_q[p] <= '0;
            end
        end else begin
            rvalid_q <= rvalid_d;
            prio_q   <= prio_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                sel_q[p]  <= sel_d[p];
                hold_q[p] <= hold_d[p];
            end
        end
    end

    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign rdata0  = rdata_mux[0];
    assign rdata1  = rdata_mux[1];
endmodule
